// File: rtl/aer_event_tx.sv
// AER event transmitter: latches event pulses, requests the arbiter,
// encodes the grant and ships one address per 4-phase req/ack handshake.
module aer_event_tx #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_W      = $clog2(NUM_PORTS),
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [NUM_PORTS-1:0] event_i,
  output logic [NUM_PORTS-1:0] req_o,
  input  logic [NUM_PORTS-1:0] gnt_i,
  output logic                 aer_req_o,
  output logic [ADDR_W-1:0]    aer_addr_o,
  input  logic                 aer_ack_i,
  input  logic                 clr_err_i,
  output logic [NUM_PORTS-1:0] overflow_o,
  output logic                 gnt_err_o,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     event_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACKL
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] pend_q, pend_d;
  logic [NUM_PORTS-1:0] ovf_q, ovf_d;
  logic                 gerr_q, gerr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 aer_req_q, aer_req_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  logic                 ack_s;
  logic [NUM_PORTS-1:0] g;
  logic [NUM_PORTS-1:0] acc;
  logic [ADDR_W-1:0]    acc_idx;
  logic                 multi;
  int                   nset;

  // Shift the asynchronous ack through the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], aer_ack_i};
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Qualify the grant and pick its lowest set bit
  always_comb begin
    g       = '0;
    acc     = '0;
    acc_idx = '0;
    nset    = 0;
    if (state_q == IDLE) begin
      g = gnt_i & pend_q;
    end
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (g[i]) begin
        acc_idx = ADDR_W'(i);
        nset    = nset + 1;
      end
    end
    multi = (nset > 1);
    if (|g) begin
      acc[acc_idx] = 1'b1;
    end
  end

  // Next state, pending bookkeeping and sticky error flags
  always_comb begin
    state_d   = state_q;
    aer_req_d = aer_req_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    pend_d    = (pend_q & ~acc) | event_i;
    ovf_d     = clr_err_i ? '0 : ovf_q;
    ovf_d     = ovf_d | (event_i & pend_q & ~acc);
    gerr_d    = clr_err_i ? 1'b0 : gerr_q;
    unique case (state_q)
      IDLE: begin
        if (|g) begin
          addr_d    = acc_idx;
          aer_req_d = 1'b1;
          state_d   = REQ;
          if (multi) begin
            gerr_d = 1'b1;
          end
        end else if (|pend_q) begin
          gerr_d = 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          aer_req_d = 1'b0;
          state_d   = ACKL;
        end
      end
      ACKL: begin
        if (!ack_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        aer_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      ovf_q     <= '0;
      gerr_q    <= 1'b0;
      addr_q    <= '0;
      aer_req_q <= 1'b0;
      cnt_q     <= '0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      gerr_q    <= gerr_d;
      addr_q    <= addr_d;
      aer_req_q <= aer_req_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
    end
  end

  assign req_o       = (state_q == IDLE) ? pend_q : '0;
  assign aer_req_o   = aer_req_q;
  assign aer_addr_o  = addr_q;
  assign overflow_o  = ovf_q;
  assign gnt_err_o   = gerr_q;
  assign busy_o      = (state_q != IDLE);
  assign event_cnt_o = cnt_q;

endmodule

// File: doc/aer_event_tx.md
Name: aer_event_tx

Overview:
- Requester and transmitter side of the fixed-priority grant arbiter used in the event path.
- Latches per-port event pulses into pending requests and drives them to the arbiter as `req_o`.
- Accepts the arbiter's one-hot grant and encodes it to a binary address.
- Sends each granted address off-block over a 4-phase AER req/ack handshake; one event is in flight at a time.

Parameters:
- NUM_PORTS, 4, number of event sources; must match the arbiter.
- ADDR_W, $clog2(NUM_PORTS) (2), width of the encoded address.
- SYNC_STAGES, 2, flop stages on the asynchronous `aer_ack_i`; minimum 2.
- CNT_W, 16, width of the completed-event counter.

Ports:
- `clk_i`  in  1  single clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `event_i`  in  NUM_PORTS  single-cycle event pulses, one bit per source.
- `req_o`  out  NUM_PORTS  pending requests to the arbiter.
- `gnt_i`  in  NUM_PORTS  grant from the arbiter; combinational response to `req_o` in the same cycle.
- `aer_req_o`  out  1  AER request, 4-phase.
- `aer_addr_o`  out  ADDR_W  AER address; stable whenever `aer_req_o`=1.
- `aer_ack_i`  in  1  AER acknowledge; asynchronous, synchronised internally.
- `clr_err_i`  in  1  synchronous clear of the sticky error flags.
- `overflow_o`  out  NUM_PORTS  sticky: an event was merged into an already-pending request.
- `gnt_err_o`  out  1  sticky: the masked grant was not one-hot while `req_o`≠0.
- `busy_o`  out  1  high when a handshake is in progress (state≠IDLE).
- `event_cnt_o`  out  CNT_W  count of completed handshakes.

Behaviour:
- Reset (async, `reset_n_i`=0) clears everything: pending=0, `req_o`=0, `aer_req_o`=0, `aer_addr_o`=0, `overflow_o`=0, `gnt_err_o`=0, `event_cnt_o`=0, synchroniser=0, state=IDLE.
- Reset mid-handshake abandons the transfer; the in-flight event is lost; no partial state is retained.
- Pending register:
  - pending[i] is set on the edge after `event_i[i]`=1.
  - pending[i] is cleared on the edge at which port i is accepted.
  - If port i is accepted and `event_i[i]`=1 in the same cycle, pending[i] stays 1. This is a new event, not an overflow.
  - If `event_i[i]`=1 while pending[i]=1 and port i is not accepted that cycle: the event is merged and `overflow_o[i]` is set.
- `req_o` = pending when state=IDLE, else 0. The arbiter therefore sees no requests during a handshake.
- Grant qualification: g = `gnt_i` & pending, evaluated only in IDLE. `gnt_i` is ignored in all other states.
- IDLE, g one-hot:
  - latch `aer_addr_o` = index of the set bit; clear that pending bit; go to REQ.
- IDLE, g has multiple bits:
  - set `gnt_err_o`; accept the lowest index only; go to REQ.
- IDLE, `req_o`≠0 and g=0:
  - set `gnt_err_o`; stay in IDLE; retry next cycle.
- State machine (let ack_s = `aer_ack_i` after SYNC_STAGES flops):
  - REQ: `aer_req_o`=1. When ack_s=1, go to ACKL; `aer_req_o` falls on that edge.
  - ACKL: `aer_req_o`=0. When ack_s=0, increment `event_cnt_o` (wraps modulo 2^CNT_W) and go to IDLE.
  - IDLE: `aer_req_o`=0.
- `aer_addr_o` holds its last value outside REQ.
- Latency:
  - `event_i` at cycle 0 → `req_o` in cycle 1 → `aer_req_o`=1 in cycle 2, assuming IDLE and the arbiter grants.
  - `aer_ack_i` rising → `aer_req_o` falls SYNC_STAGES+1 edges later.
- Throughput: the minimum handshake period is 2·SYNC_STAGES+3 cycles with an immediately responding receiver.
- Simultaneous pending requests: the arbiter order applies (port 0 highest). Lower ports can starve under sustained port-0 traffic; this is accepted.
- `clr_err_i`=1 clears `overflow_o` and `gnt_err_o` on the next edge. A new error event in the same cycle wins (flag stays set).
- `busy_o` = (state≠IDLE); it is registered with the state.

Test Plan:
- Reset, then a single `event_i`=4'b0100 → `req_o`=4'b0100 one cycle later; `aer_req_o`=1 with `aer_addr_o`=2 the cycle after. Ack high, then low → `event_cnt_o`=1, `busy_o`=0.
- `event_i`=4'b1010 in one cycle, with the real priority arbiter attached → addresses sent in order 1, then 3. `req_o`=0 throughout each handshake; `event_cnt_o`=2.
- Hold `aer_ack_i`=0 and pulse port 0 three times during REQ → one pending bit only, `overflow_o`=4'b0001. After the ack completes, address 0 is sent once more. `clr_err_i` → `overflow_o`=0.
- Accept port 2 while `event_i[2]`=1 in the same cycle → pending[2] remains 1 and `overflow_o[2]`=0. Port 2 is sent twice in total.
- Force `gnt_i`=4'b0110 with pending=4'b0110 → `gnt_err_o`=1 and address 1 is sent. Force `gnt_i`=0 with pending≠0 → `gnt_err_o`=1 and state stays IDLE.
- Assert `reset_n_i`=0 asynchronously while in REQ with `aer_addr_o`=3 → `aer_req_o`=0, all outputs zero immediately. Event at the cycle after release → normal first transfer.
